// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad row/column map and scanner state encoding.
package calc_pkg;

   localparam logic [3:0] KEY_0    = 4'h0;
   localparam logic [3:0] KEY_1    = 4'h1;
   localparam logic [3:0] KEY_2    = 4'h2;
   localparam logic [3:0] KEY_3    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_7    = 4'h7;
   localparam logic [3:0] KEY_8    = 4'h8;
   localparam logic [3:0] KEY_9    = 4'h9;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] PRESSED  = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   // Indexed by {row, col}; element 0 (row0, col0) is the "1" key.
   localparam logic [15:0][3:0] KEY_MAP = {
      KEY_D, KEY_HASH, KEY_0, KEY_STAR,
      KEY_C, KEY_9,    KEY_8, KEY_7,
      KEY_B, KEY_6,    KEY_5, KEY_4,
      KEY_A, KEY_3,    KEY_2, KEY_1
   };

   // Returns {exactly_one_low, column_index} for an active-low column pattern.
   function automatic logic [2:0] decode_col(input logic [3:0] col);
      case (col)
         4'b1110: return 3'b100;
         4'b1101: return 3'b101;
         4'b1011: return 3'b110;
         4'b0111: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones (idle pulled-up level).
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, column debounce, key code with one-cycle event strobe.
module keypad_scanner
   import calc_pkg::*;
#(
   parameter int SCAN_DIV     = 40,
   parameter int DEBOUNCE_CNT = 200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [1:0] dbg_state
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CNT);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

   logic [3:0]    col_s;
   logic [1:0]    state;
   logic [1:0]    row_idx;
   logic [SW-1:0] slot_cnt;
   logic [DW-1:0] deb_cnt;
   logic [DW-1:0] rel_cnt;
   logic [3:0]    cand_col;
   logic [1:0]    cand_idx;
   logic [2:0]    col_info;

   sync_2ff #(.WIDTH(4)) u_col_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (col_in),
      .q      (col_s)
   );

   assign col_info  = decode_col(col_s);
   assign dbg_state = state;

   always_comb begin
      row_out = ~(4'b0001 << row_idx);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= SCAN;
         row_idx   <= 2'd0;
         slot_cnt  <= '0;
         deb_cnt   <= '0;
         rel_cnt   <= '0;
         cand_col  <= 4'hF;
         cand_idx  <= 2'd0;
         key_code  <= KEY_0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               if (slot_cnt == SLOT_LAST) begin
                  if (col_info[2]) begin
                     cand_col <= col_s;
                     cand_idx <= col_info[1:0];
                     deb_cnt  <= '0;
                     state    <= DEBOUNCE;
                  end else begin
                     row_idx  <= row_idx + 2'd1;
                     slot_cnt <= '0;
                  end
               end else begin
                  slot_cnt <= slot_cnt + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (col_s == cand_col) begin
                  if (deb_cnt == DEB_LAST) begin
                     state     <= PRESSED;
                     key_valid <= 1'b1;
                     key_code  <= key_lookup(row_idx, cand_idx);
                  end else begin
                     deb_cnt <= deb_cnt + 1'b1;
                  end
               end else begin
                  state    <= SCAN;
                  row_idx  <= row_idx + 2'd1;
                  slot_cnt <= '0;
               end
            end
            PRESSED: begin
               // Extra or different columns while held are deliberately ignored.
               key_held <= 1'b1;
               if (col_s == 4'hF) begin
                  state   <= RELEASE;
                  rel_cnt <= '0;
               end
            end
            default: begin
               if (col_s == 4'hF) begin
                  if (rel_cnt == DEB_LAST) begin
                     state    <= SCAN;
                     key_held <= 1'b0;
                     row_idx  <= row_idx + 2'd1;
                     slot_cnt <= '0;
                  end else begin
                     rel_cnt <= rel_cnt + 1'b1;
                  end
               end else begin
                  state <= PRESSED;
               end
            end
         endcase
      end
   end

endmodule
